wb_regfile: RTL



---
 rtl/wb_regfile.sv | 75 +++++++
 1 files changed

// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - RV32I writeback stage: result select, 32-entry register file, write-first bypass.
// Optional retire counter output RetireCnt is enabled by defining WB_RETIRE_CNT_EN.
module wb_regfile #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            RegWriteW,
  input  logic [1:0]      ResultSrcW,
  input  logic [AW-1:0]   RdW,
  input  logic [XLEN-1:0] ALUResultW,
  input  logic [XLEN-1:0] ReadDataW,
  input  logic [XLEN-1:0] PCPlus4W,
  input  logic [AW-1:0]   A1,
  input  logic [AW-1:0]   A2,
  output logic [XLEN-1:0] RD1,
  output logic [XLEN-1:0] RD2,
`ifdef WB_RETIRE_CNT_EN
  output logic [31:0]     RetireCnt,
`endif
  output logic [XLEN-1:0] ResultW
);

  localparam int DEPTH = 2 ** AW;

  logic [XLEN-1:0] regs [DEPTH];
  logic            commit;

  assign commit = RegWriteW && (RdW != '0);

  always_comb begin
    ResultW = '0;
    case (ResultSrcW)
      2'b00:   ResultW = ALUResultW;
      2'b01:   ResultW = ReadDataW;
      2'b10:   ResultW = PCPlus4W;
      default: ResultW = '0;
    endcase
  end

  // Entry 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (commit) begin
      regs[RdW] <= ResultW;
    end
  end

  // Bypass is purely combinational so it stays live even while rst_n is low.
  always_comb begin
    RD1 = '0;
    RD2 = '0;
    if (A1 != '0) begin
      RD1 = (commit && (A1 == RdW)) ? ResultW : regs[A1];
    end
    if (A2 != '0) begin
      RD2 = (commit && (A2 == RdW)) ? ResultW : regs[A2];
    end
  end

`ifdef WB_RETIRE_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RetireCnt <= '0;
    end else if (commit) begin
      RetireCnt <= RetireCnt + 32'd1;
    end
  end
`endif

endmodule
